// File: rtl/apb_interconnect_if.sv
// APB bus bundle shared by the upstream master port (NS=1) and the fan-out slave port.
// Latency: none, wires only.
// Backpressure: pready per select line; prdata is NS slices of DW bits, slice i at [i*DW +: DW].
// Ports: paddr/pwdata/pwrite/psel/penable driven by the master side, pready/prdata/pslverr by the slave side.
interface apb_interconnect_if #(
    parameter int NS = 1,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]    paddr;
    logic [DW-1:0]    pwdata;
    logic             pwrite;
    logic [NS-1:0]    psel;
    logic             penable;
    logic [NS-1:0]    pready;
    logic [NS*DW-1:0] prdata;
    logic [NS-1:0]    pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_interconnect.sv
// One-master to NUM_SLAVES APB fabric with fixed 2^SLV_AW byte windows starting at BASE_ADDR.
// Latency: hit completes 3 cycles after master SETUP plus slave wait states; decode miss completes in 1 cycle.
// Backpressure: slave wait states stall the transfer up to TIMEOUT cycles; new master SETUPs are taken only when idle.
// Ports: clk, rst (sync, active-low); mst = upstream master port; slv = shared slave bus with one-hot psel;
//        err_cnt = saturating count of error completions (miss, timeout, slave error).
module apb_interconnect #(
    parameter int            NUM_SLAVES = 4,
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter logic [AW-1:0] BASE_ADDR  = '0,
    parameter int            SLV_AW     = 12,
    parameter int            TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                rst,
    apb_interconnect_if.slave   mst,
    apb_interconnect_if.master  slv,
    output logic [15:0]         err_cnt
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);
    localparam bit          TO_EN    = (TIMEOUT != 0);

    state_t                state_q, state_nxt;
    logic [AW-1:0]         paddr_q, paddr_nxt;
    logic [DW-1:0]         pwdata_q, pwdata_nxt;
    logic                  pwrite_q, pwrite_nxt;
    logic [NUM_SLAVES-1:0] psel_q, psel_nxt;
    logic                  penable_q, penable_nxt;
    logic                  pready_q, pready_nxt;
    logic [DW-1:0]         prdata_q, prdata_nxt;
    logic                  pslverr_q, pslverr_nxt;
    logic [15:0]           wait_q, wait_nxt;
    logic [15:0]           err_cnt_q, err_cnt_nxt;
    logic                  err_inc;

    // Window decode on the live master address
    logic [AW-1:0]         win_off, win_idx;
    logic                  hit;
    logic [NUM_SLAVES-1:0] sel_onehot;

    assign win_off    = mst.paddr - BASE_ADDR;
    assign win_idx    = win_off >> SLV_AW;
    assign hit        = (mst.paddr >= BASE_ADDR) && (win_idx < AW'(NUM_SLAVES));
    assign sel_onehot = NUM_SLAVES'(1) << win_idx;

    // Only the selected slave is observed; masking with psel_q hides every other port
    logic          slv_rdy, slv_err;
    logic [DW-1:0] slv_rdata;

    assign slv_rdy = |(slv.pready & psel_q);
    assign slv_err = |(slv.pslverr & psel_q);

    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (psel_q[i]) slv_rdata = slv_rdata | slv.prdata[i*DW +: DW];
        end
    end

    always_comb begin
        state_nxt   = state_q;
        paddr_nxt   = paddr_q;
        pwdata_nxt  = pwdata_q;
        pwrite_nxt  = pwrite_q;
        psel_nxt    = psel_q;
        penable_nxt = penable_q;
        pready_nxt  = 1'b0;
        prdata_nxt  = '0;
        pslverr_nxt = 1'b0;
        wait_nxt    = wait_q;
        err_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (mst.psel[0] && !mst.penable) begin
                    paddr_nxt  = mst.paddr;
                    pwdata_nxt = mst.pwdata;
                    pwrite_nxt = mst.pwrite;
                    wait_nxt   = '0;
                    if (hit) begin
                        psel_nxt  = sel_onehot;
                        state_nxt = SETUP;
                    end else begin
                        pready_nxt  = 1'b1;
                        pslverr_nxt = 1'b1;
                        err_inc     = 1'b1;
                        state_nxt   = RESP;
                    end
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                // A ready in the same cycle the counter hits the limit still wins
                if (slv_rdy) begin
                    psel_nxt    = '0;
                    penable_nxt = 1'b0;
                    pready_nxt  = 1'b1;
                    prdata_nxt  = pwrite_q ? '0 : slv_rdata;
                    pslverr_nxt = slv_err;
                    err_inc     = slv_err;
                    state_nxt   = RESP;
                end else if (TO_EN && (wait_q == TO_LIMIT)) begin
                    psel_nxt    = '0;
                    penable_nxt = 1'b0;
                    pready_nxt  = 1'b1;
                    pslverr_nxt = 1'b1;
                    err_inc     = 1'b1;
                    state_nxt   = RESP;
                end else begin
                    wait_nxt = wait_q + 16'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        err_cnt_nxt = (err_inc && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            wait_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_nxt;
            paddr_q   <= paddr_nxt;
            pwdata_q  <= pwdata_nxt;
            pwrite_q  <= pwrite_nxt;
            psel_q    <= psel_nxt;
            penable_q <= penable_nxt;
            pready_q  <= pready_nxt;
            prdata_q  <= prdata_nxt;
            pslverr_q <= pslverr_nxt;
            wait_q    <= wait_nxt;
            err_cnt_q <= err_cnt_nxt;
        end
    end

    assign mst.pready  = pready_q;
    assign mst.prdata  = prdata_q;
    assign mst.pslverr = pslverr_q;
    assign slv.paddr   = paddr_q;
    assign slv.pwdata  = pwdata_q;
    assign slv.pwrite  = pwrite_q;
    assign slv.psel    = psel_q;
    assign slv.penable = penable_q;
    assign err_cnt     = err_cnt_q;
endmodule
